// File: rtl/aux_pkg.sv
// Shared AUX constants and the arbiter FSM state type.
// AUX_GAP is the default inter-transaction idle gap, common with the aux engine.
package aux_pkg;

    localparam int AUX_AW  = 20;
    localparam int AUX_DW  = 8;
    localparam int AUX_GAP = 400;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } aux_arb_state_t;

endpackage

// File: rtl/aux_arbiter_if.sv
// Requester-side and engine-side AUX transaction signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface aux_arbiter_if
    import aux_pkg::*;
#(
    parameter int N = 3
) ();

    logic [N-1:0]        req;
    logic [N-1:0]        wr;
    logic [N*AUX_AW-1:0] addr;
    logic [N*AUX_DW-1:0] wdata;
    logic [N-1:0]        ack;
    logic [N-1:0]        err;
    logic [AUX_DW-1:0]   rdata;

    logic [AUX_AW-1:0]   auxaddr;
    logic [AUX_DW-1:0]   auxwdata;
    logic                auxwr;
    logic                auxreq;
    logic                auxack;
    logic                auxerr;
    logic [AUX_DW-1:0]   auxrdata;

    modport slave (
        input  req, wr, addr, wdata, auxack, auxerr, auxrdata,
        output ack, err, rdata, auxaddr, auxwdata, auxwr, auxreq
    );

    modport master (
        output req, wr, addr, wdata, auxack, auxerr, auxrdata,
        input  ack, err, rdata, auxaddr, auxwdata, auxwr, auxreq
    );

endinterface

// File: rtl/aux_rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upward, wrapping
// through N-1 to 0. Also used by the HPD/IRQ service scheduler.
module aux_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last_owner) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(last_owner) + k) % N);
            end
        end
    end

endmodule

// File: rtl/aux_arbiter.sv
// Round-robin arbiter for the single AUX engine port with a minimum idle gap.
// Defining AUX_ARB_RETRY_EN retries failed transactions up to RETRIES extra times.
module aux_arbiter #(
    parameter int N       = 3,
    parameter int GAP     = aux_pkg::AUX_GAP,
    parameter int RETRIES = 2
) (
    input  logic               clk,
    input  logic               rst,
    aux_arbiter_if.slave       bus,
    output logic               busy,
    output logic [2:0]         owner
);

    localparam int AW = aux_pkg::AUX_AW;
    localparam int DW = aux_pkg::AUX_DW;
    localparam int CW = $clog2(GAP + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

    aux_pkg::aux_arb_state_t state_q, state_d;

    logic [CW-1:0] gap_q, gap_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          retry_q, retry_d;
    logic          final_c;
    logic          pick_valid;
    logic [2:0]    pick_idx;

`ifdef AUX_ARB_RETRY_EN
    logic [1:0]    att_q, att_d;
`endif

    aux_rr_pick #(
        .N  (N),
        .IW (3)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        retry_d = retry_q;
`ifdef AUX_ARB_RETRY_EN
        att_d   = att_q;
        final_c = !bus.auxerr || (int'(att_q) >= RETRIES);
`else
        final_c = 1'b1;
`endif

        case (state_q)
            aux_pkg::IDLE: begin
                if (pick_valid) begin
                    state_d = aux_pkg::ISSUE;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    addr_d  = bus.addr[int'(pick_idx)*AW +: AW];
                    wdata_d = bus.wdata[int'(pick_idx)*DW +: DW];
                    wr_d    = bus.wr[pick_idx];
                    retry_d = 1'b0;
`ifdef AUX_ARB_RETRY_EN
                    att_d   = '0;
`endif
                end
            end
            aux_pkg::ISSUE: begin
                if (bus.auxack) begin
                    state_d = aux_pkg::GAP;
                    gap_d   = GAP_LOAD;
                    if (final_c) begin
                        ack_d   = N'(1) << owner_q;
                        err_d   = bus.auxerr ? (N'(1) << owner_q) : '0;
                        rdata_d = bus.auxrdata;
                        retry_d = 1'b0;
                    end else begin
                        retry_d = 1'b1;
`ifdef AUX_ARB_RETRY_EN
                        att_d   = att_q + 2'd1;
`endif
                    end
                end
            end
            aux_pkg::GAP: begin
                if (gap_q == '0) begin
                    // A pending retry reissues with the already-latched owner and data.
                    state_d = retry_q ? aux_pkg::ISSUE : aux_pkg::IDLE;
                    retry_d = 1'b0;
                end else begin
                    gap_d = gap_q - CW'(1);
                end
            end
            default: state_d = aux_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= aux_pkg::IDLE;
            gap_q   <= '0;
            owner_q <= '0;
            last_q  <= 3'(N - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            retry_q <= 1'b0;
`ifdef AUX_ARB_RETRY_EN
            att_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            retry_q <= retry_d;
`ifdef AUX_ARB_RETRY_EN
            att_q   <= att_d;
`endif
        end
    end

    assign bus.auxreq   = (state_q == aux_pkg::ISSUE);
    assign bus.auxaddr  = addr_q;
    assign bus.auxwdata = wdata_q;
    assign bus.auxwr    = wr_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign busy         = (state_q != aux_pkg::IDLE);
    assign owner        = owner_q;

endmodule
